// File: rtl/vga_timing_ctrl_pkg.sv
// Shared timing defaults, FSM state encoding and decode helper for the VGA timing controller.
package vga_timing_ctrl_pkg;

  localparam int unsigned CntW        = 10;

  localparam int unsigned DefClkDiv   = 4;
  localparam int unsigned DefHActive  = 640;
  localparam int unsigned DefHFp      = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBp      = 48;
  localparam int unsigned DefVActive  = 480;
  localparam int unsigned DefVFp      = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBp      = 33;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Inclusive window test on a counter value.
  function automatic logic in_window(input logic [CntW-1:0] val, input int unsigned lo,
                                     input int unsigned hi);
    return (val >= CntW'(lo)) && (val <= CntW'(hi));
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis_counter.sv
// Wrap-around counter with combinational terminal-count flag; used for divider, h and v axes.
module vga_timing_ctrl_axis_counter
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = CntW,
  parameter int unsigned MAX_VAL = 799
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  assign o_count = r_count;
  assign o_tc    = (r_count == WIDTH'(MAX_VAL));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: run/drain FSM over pixel-divider, h and v counters with registered decode.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  output logic            o_pix_tick,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_video_on,
  output logic [CntW-1:0] o_pix_x,
  output logic [CntW-1:0] o_pix_y,
  output logic            o_line_start,
  output logic            o_frame_start,
  output logic            o_busy
);

  localparam int unsigned H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  state_e          r_state;
  logic            r_pix_tick;
  logic            r_line_start;
  logic            r_frame_start;
  logic            r_busy;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_video_on;
  logic [CntW-1:0] r_pix_x;
  logic [CntW-1:0] r_pix_y;

  logic            w_active;
  logic            w_div_tc_raw;
  logic            w_h_tc_raw;
  logic            w_v_tc_raw;
  logic            w_div_tc;
  logic            w_line_end;
  logic            w_frame_end;
  logic [CntW-1:0] w_div_cnt;
  logic [CntW-1:0] w_h_cnt;
  logic [CntW-1:0] w_v_cnt;
  logic            w_unused_div;

  // Counters only move in RUN/DRAIN; they reach 0 on the final wrap, so IDLE holds them at 0.
  assign w_active     = (r_state != StIdle);
  assign w_div_tc     = w_active & w_div_tc_raw;
  assign w_line_end   = w_div_tc & w_h_tc_raw;
  assign w_frame_end  = w_line_end & w_v_tc_raw;
  assign w_unused_div = ^w_div_cnt;

  vga_timing_ctrl_axis_counter #(
    .WIDTH   (CntW),
    .MAX_VAL (CLK_DIV - 1)
  ) u_div_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_active),
    .o_count (w_div_cnt),
    .o_tc    (w_div_tc_raw)
  );

  vga_timing_ctrl_axis_counter #(
    .WIDTH   (CntW),
    .MAX_VAL (H_TOTAL - 1)
  ) u_h_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_div_tc),
    .o_count (w_h_cnt),
    .o_tc    (w_h_tc_raw)
  );

  vga_timing_ctrl_axis_counter #(
    .WIDTH   (CntW),
    .MAX_VAL (V_TOTAL - 1)
  ) u_v_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_line_end),
    .o_count (w_v_cnt),
    .o_tc    (w_v_tc_raw)
  );

  // Strobes are registered alongside the state so that the wrap back into IDLE emits none.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_pix_tick    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pix_tick    <= w_div_tc;
      r_line_start  <= w_line_end;
      r_frame_start <= w_frame_end;
      unique case (r_state)
        StIdle: begin
          if (i_en) begin
            r_state <= StRun;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          if (!i_en) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (i_en) begin
            r_state <= StRun;
          end else if (w_frame_end) begin
            r_state       <= StIdle;
            r_busy        <= 1'b0;
            r_pix_tick    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
      r_pix_x    <= '0;
      r_pix_y    <= '0;
    end else if (r_state == StIdle) begin
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
      r_pix_x    <= '0;
      r_pix_y    <= '0;
    end else begin
      r_hsync    <= in_window(w_h_cnt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= in_window(w_v_cnt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      r_video_on <= (w_h_cnt < CntW'(H_ACTIVE)) && (w_v_cnt < CntW'(V_ACTIVE));
      r_pix_x    <= w_h_cnt;
      r_pix_y    <= w_v_cnt;
    end
  end

  assign o_pix_tick    = r_pix_tick;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;
  assign o_busy        = r_busy;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_pix_x       = r_pix_x;
  assign o_pix_y       = r_pix_y;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a shrunken 16x12-pixel raster, two clocks per pixel.
module tb_vga_timing_ctrl;

  // Reduced raster: H 8+2+3+3=16, V 6+2+2+2=12, one frame = 192 ticks = 384 clks.
  localparam int HTot = 16;
  localparam int VTot = 12;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       o_pix_tick;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_video_on;
  logic [9:0] o_pix_x;
  logic [9:0] o_pix_y;
  logic       o_line_start;
  logic       o_frame_start;
  logic       o_busy;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t exp_q[$];
  int   hm = 0;
  int   vm = 0;

  vga_timing_ctrl #(
    .CLK_DIV  (2),
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .SYNC_POL (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .o_pix_tick    (o_pix_tick),
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_video_on    (o_video_on),
    .o_pix_x       (o_pix_x),
    .o_pix_y       (o_pix_y),
    .o_line_start  (o_line_start),
    .o_frame_start (o_frame_start),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pixel after the next tick; sync windows hand-derived: h in [10,12], v in [8,9].
  task automatic push_next();
    exp_t e;
    hm = (hm + 1) % HTot;
    if (hm == 0) vm = (vm + 1) % VTot;
    e.x   = 10'(hm);
    e.y   = 10'(vm);
    e.hs  = !((hm >= 10) && (hm <= 12));
    e.vs  = !((vm >= 8) && (vm <= 9));
    e.von = (hm < 8) && (vm < 6);
    e.ls  = (hm == 0);
    e.fs  = (hm == 0) && (vm == 0);
    exp_q.push_back(e);
  endtask

  task automatic tick_run(input int n);
    for (int i = 0; i < n; i++) begin
      push_next();
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_tick"}, o_pix_tick, 0);
    check({tag, "_hsync"}, o_hsync, 1);
    check({tag, "_vsync"}, o_vsync, 1);
    check({tag, "_video_on"}, o_video_on, 0);
    check({tag, "_pix_x"}, o_pix_x, 0);
    check({tag, "_pix_y"}, o_pix_y, 0);
    check({tag, "_line_start"}, o_line_start, 0);
    check({tag, "_frame_start"}, o_frame_start, 0);
  endtask

  // Monitor: pops on each pix_tick; coordinates/decode are compared one clock later.
  int   cyc = 0;
  int   last_ls = -1;
  int   last_fs = -1;
  int   hs_low = 0;
  int   vs_low = 0;
  int   von_cnt = 0;
  bit   pend_v = 1'b0;
  exp_t pend;

  always @(negedge clk) begin
    cyc++;
    if (pend_v) begin
      check("pix_x", o_pix_x, pend.x);
      check("pix_y", o_pix_y, pend.y);
      check("hsync", o_hsync, pend.hs);
      check("vsync", o_vsync, pend.vs);
      check("video_on", o_video_on, pend.von);
      if (o_video_on) von_cnt++;
      pend_v = 1'b0;
    end
    if (o_pix_tick) begin
      check("tick_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        pend   = exp_q.pop_front();
        pend_v = 1'b1;
        check("line_start", o_line_start, pend.ls);
        check("frame_start", o_frame_start, pend.fs);
      end
    end else begin
      check("stray_strobe", o_line_start | o_frame_start, 0);
    end
    if (!o_busy || rst) begin
      last_ls = -1;
      last_fs = -1;
      hs_low  = 0;
      vs_low  = 0;
      von_cnt = 0;
    end else begin
      if (o_line_start) begin
        if (last_ls >= 0) check("line_period", cyc - last_ls, 32);
        last_ls = cyc;
      end
      if (o_frame_start) begin
        if (last_fs >= 0) begin
          check("frame_period", cyc - last_fs, 384);
          check("active_ticks", von_cnt, 48);
        end
        last_fs = cyc;
        von_cnt = 0;
      end
      if (!o_hsync) begin
        if (hs_low == 0) check("hsync_start_x", o_pix_x, 10);
        hs_low++;
      end else if (hs_low != 0) begin
        check("hsync_width", hs_low, 6);
        hs_low = 0;
      end
      if (!o_vsync) begin
        if (vs_low == 0) check("vsync_start_y", o_pix_y, 8);
        vs_low++;
      end else if (vs_low != 0) begin
        check("vsync_width", vs_low, 64);
        vs_low = 0;
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    repeat (100) @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // Two full frames, then drain / resume / drain to IDLE inside frame 3.
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    #1;
    check("run_busy", o_busy, 1);
    hm = 0;
    vm = 0;
    tick_run(384 + 48);
    #1 en = 1'b0;
    tick_run(48);
    #1;
    check("drain_busy", o_busy, 1);
    en = 1'b1;
    tick_run(32);
    #1 en = 1'b0;
    tick_run(63);
    #1;
    check("drain_last_busy", o_busy, 1);
    repeat (2) @(posedge clk);
    #1;
    check("drain_done_busy", o_busy, 0);
    check("drain_done_tick", o_pix_tick, 0);
    @(posedge clk);
    #1;
    check_reset_outputs("post_drain");
    repeat (20) @(posedge clk);

    // Restart, then async reset at (5,7).
    @(negedge clk) en = 1'b1;
    @(posedge clk);
    hm = 0;
    vm = 0;
    tick_run(7 * 16 + 5);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained_pre_rst", exp_q.size(), 0);
    check("pre_rst_pix_x", o_pix_x, 5);
    check("pre_rst_pix_y", o_pix_y, 7);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (5) @(posedge clk);
    #1;
    check("rst_hold_busy", o_busy, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    hm = 0;
    vm = 0;
    tick_run(2 * 16 + 8);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained_end", exp_q.size(), 0);
    check("end_pix_x", o_pix_x, 8);
    check("end_pix_y", o_pix_y, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
